// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants, buffer entry type and count-width helper for instruction fetch
//
// Contents:
//   FETCH_RESET_PC   default first fetch address after reset
//   INSTR_NOP        canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t    one buffer entry: {pc, instr}
//   fetch_cnt_width  bits needed to count 0..depth inclusive
package instr_fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int fetch_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - DEPTH-entry FIFO of {pc, instr} entries with push/pop/clear and occupancy count
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write one entry (caller guarantees not full unless popping)
//   i_pop           remove head entry (caller guarantees not empty)
//   i_clear         drop all entries; has priority over push/pop
//   o_head          entry at the read pointer (storage, not gated by count)
//   o_count         number of valid entries
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = fetch_cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap naturally on overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_clear) begin
      // Keep the read pointer where it is so the head storage does not jump.
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (i_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, credit-limited imem requests, in-order response buffer, redirect flush
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr          word read request, accepted when i_imem_ready
//   i_imem_rvalid/i_imem_rdata      in-order read responses
//   o_instr_valid/o_instr/o_pc      buffer head towards decode, consumed on i_instr_ready
//   i_redirect/i_redirect_pc        taken branch/jump, flushes and restarts fetch
//   o_err_misaligned                one-cycle pulse after a redirect to a non-word-aligned target
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_err_misaligned
);

  localparam int          CW      = fetch_cnt_width(DEPTH);
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  logic          err_q;
  logic          accept;
  logic          resp_keep;
  logic [31:0]   redirect_base;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign redirect_base = {i_redirect_pc[31:2], 2'b00};

  // Every in-flight read owns a buffer slot, so a response can always be pushed.
  assign o_imem_req  = i_rst_n && !i_redirect &&
                       (({1'b0, outstanding_q} + {1'b0, count}) < CREDITS);
  assign o_imem_addr = req_pc_q;
  assign accept      = o_imem_req && i_imem_ready;
  assign resp_keep   = i_imem_rvalid && (drop_q == '0);
  assign push_data   = '{pc: resp_pc_q, instr: i_imem_rdata};

  always_comb begin
    req_pc_d      = req_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(i_imem_rvalid);
    drop_d        = drop_q;
    if (i_redirect) begin
      req_pc_d  = redirect_base;
      resp_pc_d = redirect_base;
      // Everything still in flight after this cycle's response is stale,
      // including reads already marked stale by an earlier redirect.
      drop_d    = outstanding_q - CW'(i_imem_rvalid);
    end else begin
      if (accept)                          req_pc_d  = req_pc_q + 32'd4;
      if (resp_keep)                       resp_pc_d = resp_pc_q + 32'd4;
      if (i_imem_rvalid && drop_q != '0)   drop_d    = drop_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_pc_q      <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      req_pc_q      <= req_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      err_q         <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
    end
  end

  // Clear has priority inside the FIFO, so a redirect voids this cycle's push and pop.
  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (resp_keep),
    .i_data  (push_data),
    .i_pop   (o_instr_valid && i_instr_ready),
    .i_clear (i_redirect),
    .o_head  (head),
    .o_count (count)
  );

  assign o_instr_valid    = (count != '0);
  assign o_instr          = head.instr;
  assign o_pc             = head.pc;
  assign o_err_misaligned = err_q;

endmodule
